rvfi_mem_responder: RTL and testbench
=====================================

// Module: rvfi_mem_responder
// PURPOSE
//  Parametrised instruction/data memory model for the formal and simulation harness around the core.
//  Replaces free-running random imem/dmem data with a req/ready/rvalid handshake per port, backed by
//  a word-addressed shared RAM (dmem read/write with byte strobes, imem read-only).
//  Adds a fixed access latency plus bounded, externally driven stalls, so the core is exercised under wait states.
// PARAMETERS
//  ADDR_W      32  byte-address width of both ports
//  DATA_W      32  data width; byte strobe width DATA_W/8
//  DEPTH_LOG2  10  RAM depth in words (2**DEPTH_LOG2)
//  LATENCY     1   fixed cycles from accept to rvalid, minimum 1
//  RAND_STALL  1   1: honour io_*_stall inputs; 0: ignore them
//  MAX_STALL   3   max consecutive extra stall cycles per request (saturating, 0..15)
// PORTS
//  clock          in   1         single clock
//  reset          in   1         asynchronous, active-low reset
//  io_imem_req    in   1         fetch request
//  io_imem_addr   in   ADDR_W    fetch byte address
//  io_imem_ready  out  1         request accepted when req & ready
//  io_imem_rvalid out  1         one-cycle response strobe
//  io_imem_rdata  out  DATA_W    fetch data, valid with rvalid
//  io_imem_err    out  1         fetch fault, valid with rvalid
//  io_imem_stall  in   1         extra-stall request (formal rand reg)
//  io_dmem_req    in   1         data request
//  io_dmem_we     in   1         1 write / 0 read
//  io_dmem_addr   in   ADDR_W    data byte address
//  io_dmem_wdata  in   DATA_W    write data
//  io_dmem_wstrb  in   DATA_W/8  byte enables (write only)
//  io_dmem_ready  out  1         request accepted when req & ready
//  io_dmem_rvalid out  1         one-cycle response strobe
//  io_dmem_rdata  out  DATA_W    read data (0 for writes)
//  io_dmem_err    out  1         data fault, valid with rvalid
//  io_dmem_stall  in   1         extra-stall request (formal rand reg)
// BEHAVIOUR
//  - Reset (reset=0, async): both FSMs IDLE, counters 0, ready=1, rvalid=0, rdata=0, err=0. RAM contents not reset.
//  - Per port independent FSM IDLE->WAIT->RESP->IDLE; ready=1 only in IDLE.
//  - Accept (IDLE, req=1): latch addr/we/wdata/wstrb; lat_cnt<=LATENCY-1, stall_cnt<=0; enter WAIT.
//  - WAIT: if RAND_STALL & stall & stall_cnt<MAX_STALL: stall_cnt++, lat_cnt held. Else if lat_cnt!=0: lat_cnt--.
//    Else: perform access, enter RESP.
//  - RESP: rvalid=1 for exactly one cycle, rdata/err driven; next IDLE. No response backpressure; back-to-back
//    requests therefore see ready low for LATENCY+1+stalls cycles.
//  - Response cycle = accept + LATENCY + 1 + stalls taken (stalls <= MAX_STALL).
//  - Word index = addr[DEPTH_LOG2+1:2]. Fault if addr[ADDR_W-1:DEPTH_LOG2+2]!=0 or addr[1:0]!=0.
//    Fault: err=1, rdata=0, no RAM write.
//  - dmem write: only bytes with wstrb[i]=1 updated; wstrb=0 is a legal no-op write. rdata=0 on writes.
//  - Same-edge imem read and dmem write to same word: imem returns pre-write data (read-before-write).
//  - req deasserted or addr changed after accept: ignored (latched values used).
//  - Reset mid-transaction: transaction dropped, no rvalid, partial write never happens (write occurs only
//    on the WAIT->RESP edge).
//  - All rdata/err registered; no combinational path from inputs to rvalid/rdata.
// TESTING
//  1 Reset, LATENCY=1, RAND_STALL=0, dmem write 0xDEADBEEF @0x10 wstrb=F -> rvalid 2 cycles after accept, err=0.
//  2 imem read 0x10 -> rdata=0xDEADBEEF at accept+2; ready low during WAIT/RESP.
//  3 dmem write 0x000000AA @0x10 wstrb=0001 then read -> 0xDEADBEAA.
//  4 RAND_STALL=1, MAX_STALL=3, stall held 1 -> rvalid exactly at accept+5, never later.
//  5 dmem read @0x2 and @0x1000 (DEPTH_LOG2=10) -> err=1, rdata=0; following read @0x10 unchanged.
//  6 Same-cycle imem read/dmem write 0x12345678 @0x20 -> imem old data; reset low in WAIT -> no rvalid,
//    @0x20 keeps old data.

Source files
------------

// File: rtl/rvfi_mem_responder.sv
// Handshaked imem/dmem memory model over a shared word RAM: fixed latency plus
// bounded external stalls per request, registered responses, address fault checks.

module rvfi_mem_port #(
  parameter int LATENCY    = 1,
  parameter int RAND_STALL = 1,
  parameter int MAX_STALL  = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic stall,
  output logic ready,
  output logic fire,
  output logic rvalid
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]    state;
  logic [LW-1:0] lat_cnt;
  logic [3:0]    stall_cnt;
  logic          stall_take;

  // Stalls take priority over latency countdown, capped per request.
  assign stall_take = (RAND_STALL != 0) && stall && (stall_cnt < 4'(MAX_STALL));
  assign fire       = (state == WAIT) && !stall_take && (lat_cnt == '0);
  assign ready      = (state == IDLE);
  assign rvalid     = (state == RESP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state     <= WAIT;
          lat_cnt   <= LW'(LATENCY - 1);
          stall_cnt <= '0;
        end
        WAIT: begin
          if (stall_take)          stall_cnt <= stall_cnt + 4'd1;
          else if (lat_cnt != '0) lat_cnt   <= lat_cnt - LW'(1);
          else                    state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module rvfi_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1,
  parameter int RAND_STALL = 1,
  parameter int MAX_STALL  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_imem_req,
  input  logic [ADDR_W-1:0]   io_imem_addr,
  output logic                io_imem_ready,
  output logic                io_imem_rvalid,
  output logic [DATA_W-1:0]   io_imem_rdata,
  output logic                io_imem_err,
  input  logic                io_imem_stall,
  input  logic                io_dmem_req,
  input  logic                io_dmem_we,
  input  logic [ADDR_W-1:0]   io_dmem_addr,
  input  logic [DATA_W-1:0]   io_dmem_wdata,
  input  logic [DATA_W/8-1:0] io_dmem_wstrb,
  output logic                io_dmem_ready,
  output logic                io_dmem_rvalid,
  output logic [DATA_W-1:0]   io_dmem_rdata,
  output logic                io_dmem_err,
  input  logic                io_dmem_stall
);
  localparam int SW = DATA_W / 8;

  logic              i_fire, d_fire;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic [SW-1:0]     d_wstrb;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic              i_fault, d_fault;
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  rvfi_mem_port #(.LATENCY(LATENCY), .RAND_STALL(RAND_STALL), .MAX_STALL(MAX_STALL)) u_imem (
    .clock(clock), .reset(reset), .req(io_imem_req), .stall(io_imem_stall),
    .ready(io_imem_ready), .fire(i_fire), .rvalid(io_imem_rvalid));

  rvfi_mem_port #(.LATENCY(LATENCY), .RAND_STALL(RAND_STALL), .MAX_STALL(MAX_STALL)) u_dmem (
    .clock(clock), .reset(reset), .req(io_dmem_req), .stall(io_dmem_stall),
    .ready(io_dmem_ready), .fire(d_fire), .rvalid(io_dmem_rvalid));

  function automatic logic is_fault(input logic [ADDR_W-1:0] a);
    return (a[ADDR_W-1:DEPTH_LOG2+2] != '0) || (a[1:0] != 2'b00);
  endfunction

  assign i_idx   = i_addr[DEPTH_LOG2+1:2];
  assign d_idx   = d_addr[DEPTH_LOG2+1:2];
  assign i_fault = is_fault(i_addr);
  assign d_fault = is_fault(d_addr);

  // Request fields are captured at accept; later input changes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_addr  <= '0;
      d_addr  <= '0;
      d_we    <= 1'b0;
      d_wdata <= '0;
      d_wstrb <= '0;
    end else begin
      if (io_imem_req && io_imem_ready) i_addr <= io_imem_addr;
      if (io_dmem_req && io_dmem_ready) begin
        d_addr  <= io_dmem_addr;
        d_we    <= io_dmem_we;
        d_wdata <= io_dmem_wdata;
        d_wstrb <= io_dmem_wstrb;
      end
    end
  end

  // Nonblocking RAM update gives read-before-write against a same-edge imem read.
  always_ff @(posedge clock) begin
    if (d_fire && d_we && !d_fault) begin
      for (int b = 0; b < SW; b++)
        if (d_wstrb[b]) mem[d_idx][b*8 +: 8] <= d_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_imem_rdata <= '0;
      io_imem_err   <= 1'b0;
      io_dmem_rdata <= '0;
      io_dmem_err   <= 1'b0;
    end else begin
      if (i_fire) begin
        io_imem_rdata <= i_fault ? '0 : mem[i_idx];
        io_imem_err   <= i_fault;
      end
      if (d_fire) begin
        io_dmem_rdata <= (d_fault || d_we) ? '0 : mem[d_idx];
        io_dmem_err   <= d_fault;
      end
    end
  end
endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Scoreboard bench: drivers queue expected responses, per-port monitors check
// data, error flag and exact response cycle whenever rvalid is seen.

module tb_rvfi_mem_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_imem_req = 1'b0, io_imem_ready, io_imem_rvalid, io_imem_err, io_imem_stall = 1'b0;
  logic [31:0] io_imem_addr = '0, io_imem_rdata;
  logic        io_dmem_req = 1'b0, io_dmem_we = 1'b0, io_dmem_ready, io_dmem_rvalid, io_dmem_err;
  logic        io_dmem_stall = 1'b0;
  logic [31:0] io_dmem_addr = '0, io_dmem_wdata = '0, io_dmem_rdata;
  logic [3:0]  io_dmem_wstrb = '0;

  rvfi_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(1),
                       .RAND_STALL(1), .MAX_STALL(3)) dut (
    .clock(clock), .reset(reset),
    .io_imem_req(io_imem_req), .io_imem_addr(io_imem_addr), .io_imem_ready(io_imem_ready),
    .io_imem_rvalid(io_imem_rvalid), .io_imem_rdata(io_imem_rdata), .io_imem_err(io_imem_err),
    .io_imem_stall(io_imem_stall),
    .io_dmem_req(io_dmem_req), .io_dmem_we(io_dmem_we), .io_dmem_addr(io_dmem_addr),
    .io_dmem_wdata(io_dmem_wdata), .io_dmem_wstrb(io_dmem_wstrb), .io_dmem_ready(io_dmem_ready),
    .io_dmem_rvalid(io_dmem_rvalid), .io_dmem_rdata(io_dmem_rdata), .io_dmem_err(io_dmem_err),
    .io_dmem_stall(io_dmem_stall));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clock) begin
    if (io_imem_rvalid) begin
      if (iq.size() == 0) flag("imem_unexpected_rvalid");
      else begin
        exp_t e;
        e = iq.pop_front();
        check("imem_rdata", io_imem_rdata, e.data);
        check("imem_err", 32'(io_imem_err), 32'(e.err));
        check("imem_resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clock) begin
    if (io_dmem_rvalid) begin
      if (dq.size() == 0) flag("dmem_unexpected_rvalid");
      else begin
        exp_t e;
        e = dq.pop_front();
        check("dmem_rdata", io_dmem_rdata, e.data);
        check("dmem_err", 32'(io_dmem_err), 32'(e.err));
        check("dmem_resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Response expected at accept + LATENCY(1) + 1 + stalls.
  task automatic dmem_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_data,
                         input logic exp_err, input int stalls);
    exp_t e;
    int t;
    t = 0;
    @(negedge clock);
    while (!io_dmem_ready && t < 50) begin @(negedge clock); t++; end
    if (!io_dmem_ready) begin flag("dmem_ready_timeout"); return; end
    io_dmem_req = 1'b1; io_dmem_we = we; io_dmem_addr = addr;
    io_dmem_wdata = wdata; io_dmem_wstrb = wstrb;
    e.data = exp_data; e.err = exp_err; e.cyc = cyc + 2 + stalls;
    dq.push_back(e);
    @(negedge clock);
    check("dmem_ready_busy", 32'(io_dmem_ready), 32'd0);
    io_dmem_req = 1'b0; io_dmem_addr = 32'h0000_0040; io_dmem_wdata = ~wdata; io_dmem_wstrb = 4'hF;
    t = 0;
    while (dq.size() != 0 && t < 50) begin @(negedge clock); t++; end
    if (dq.size() != 0) begin flag("dmem_resp_timeout"); dq.delete(); end
  endtask

  task automatic imem_op(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int stalls);
    exp_t e;
    int t;
    t = 0;
    @(negedge clock);
    while (!io_imem_ready && t < 50) begin @(negedge clock); t++; end
    if (!io_imem_ready) begin flag("imem_ready_timeout"); return; end
    io_imem_req = 1'b1; io_imem_addr = addr;
    e.data = exp_data; e.err = exp_err; e.cyc = cyc + 2 + stalls;
    iq.push_back(e);
    @(negedge clock);
    check("imem_ready_busy", 32'(io_imem_ready), 32'd0);
    io_imem_req = 1'b0; io_imem_addr = 32'h0000_0044;
    t = 0;
    while (iq.size() != 0 && t < 50) begin @(negedge clock); t++; end
    if (iq.size() != 0) begin flag("imem_resp_timeout"); iq.delete(); end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_imem_ready", 32'(io_imem_ready), 32'd1);
    check("rst_dmem_ready", 32'(io_dmem_ready), 32'd1);
    check("rst_imem_rvalid", 32'(io_imem_rvalid), 32'd0);
    check("rst_dmem_rvalid", 32'(io_dmem_rvalid), 32'd0);
    check("rst_imem_rdata", io_imem_rdata, 32'd0);
    check("rst_dmem_rdata", io_dmem_rdata, 32'd0);
    check("rst_imem_err", 32'(io_imem_err), 32'd0);
    check("rst_dmem_err", 32'(io_dmem_err), 32'd0);
    reset = 1'b1;

    // Basic write/read, byte strobes, no-op strobe
    dmem_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    imem_op(32'h10, 32'hDEADBEEF, 1'b0, 0);
    dmem_op(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 0);
    dmem_op(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);
    dmem_op(1'b1, 32'h10, 32'h00550000, 4'h4, 32'h0, 1'b0, 0);
    dmem_op(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
    dmem_op(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE55BEAA, 1'b0, 0);

    // Stall held high: capped at MAX_STALL=3 extra cycles
    io_dmem_stall = 1'b1; io_imem_stall = 1'b1;
    dmem_op(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE55BEAA, 1'b0, 3);
    imem_op(32'h10, 32'hDE55BEAA, 1'b0, 3);
    io_dmem_stall = 1'b0; io_imem_stall = 1'b0;

    // Faults: misaligned and out-of-range, writes must not alias into word 4
    dmem_op(1'b0, 32'h2, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    dmem_op(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    dmem_op(1'b1, 32'h1010, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    dmem_op(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    imem_op(32'h1004, 32'h0, 1'b1, 0);
    dmem_op(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE55BEAA, 1'b0, 0);

    // Same-edge imem read and dmem write: imem sees old data
    dmem_op(1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0, 0);
    fork
      dmem_op(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
      imem_op(32'h20, 32'h11111111, 1'b0, 0);
    join
    imem_op(32'h20, 32'h12345678, 1'b0, 0);

    // Reset while the write is in WAIT: dropped, no response, no RAM update
    @(negedge clock);
    io_dmem_req = 1'b1; io_dmem_we = 1'b1; io_dmem_addr = 32'h20;
    io_dmem_wdata = 32'hCAFEF00D; io_dmem_wstrb = 4'hF;
    @(negedge clock);
    io_dmem_req = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_dmem_rvalid", 32'(io_dmem_rvalid), 32'd0);
    check("midrst_imem_rdata", io_imem_rdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("midrst_dmem_ready", 32'(io_dmem_ready), 32'd1);
    dmem_op(1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
